// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, control-word bit
// positions and ALU operation codes.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Bit positions inside the packed 9-bit main-control word.
    localparam int CTL_REG_DST    = 8;
    localparam int CTL_ALU_SRC    = 7;
    localparam int CTL_MEM_TO_REG = 6;
    localparam int CTL_REG_WRITE  = 5;
    localparam int CTL_MEM_READ   = 4;
    localparam int CTL_MEM_WRITE  = 3;
    localparam int CTL_BRANCH     = 2;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Builds a control word from its named fields.
    function automatic logic [8:0] ctl_word(
        input logic reg_dst, input logic alu_src, input logic mem_to_reg,
        input logic reg_write, input logic mem_read, input logic mem_write,
        input logic branch, input logic [1:0] alu_op
    );
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                mem_write, branch, alu_op};
    endfunction

endpackage

// File: rtl/id_alu_ctl.sv
// ALU control: maps the main decoder's ALUOp and the R-type funct field to an
// ALU operation code, flagging functs this datapath does not implement.
module id_alu_ctl
    import id_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       funct_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_ctl       = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_ctl = ALU_ADD;
            ALU_OP_SUB: alu_ctl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: begin
                        alu_ctl       = ALU_AND;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id.sv
// Instruction-decode stage: main control, ALU control, register fields and
// sign-extended immediate, all registered as the ID/EX boundary.
module id
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instructionIn,
    output logic [8:0]  ALUSrcB,
    output logic [3:0]  aluCtl,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] immExt,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [8:0]  main_ctl;
    logic        op_illegal;
    logic [3:0]  alu_ctl_next;
    logic        funct_illegal;
    logic [8:0]  ctl_next;
    logic [31:0] imm_next;

    assign opcode = instructionIn[31:26];

    always_comb begin
        main_ctl   = '0;
        op_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: main_ctl = ctl_word(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT);
            OP_LW:    main_ctl = ctl_word(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OP_ADD);
            OP_SW:    main_ctl = ctl_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OP_ADD);
            OP_BEQ:   main_ctl = ctl_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_SUB);
            OP_ADDI:  main_ctl = ctl_word(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_ADD);
            default:  op_illegal = 1'b1;
        endcase
    end

    id_alu_ctl u_alu_ctl (
        .alu_op        (main_ctl[1:0]),
        .funct         (instructionIn[5:0]),
        .alu_ctl       (alu_ctl_next),
        .funct_illegal (funct_illegal)
    );

    // An unsupported funct becomes a bubble: no register or memory side effects.
    assign ctl_next = funct_illegal ? 9'h000 : main_ctl;
    assign imm_next = {{16{instructionIn[15]}}, instructionIn[15:0]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            ALUSrcB <= '0;
            aluCtl  <= '0;
            rs      <= '0;
            rt      <= '0;
            rd      <= '0;
            immExt  <= '0;
            illegal <= 1'b0;
        end else begin
            ALUSrcB <= ctl_next;
            aluCtl  <= alu_ctl_next;
            rs      <= instructionIn[25:21];
            rt      <= instructionIn[20:16];
            rd      <= instructionIn[15:11];
            immExt  <= imm_next;
            illegal <= op_illegal | funct_illegal;
        end
    end

endmodule

// File: tb/tb_id.sv
// Self-checking bench for the ID stage: directed cases plus randomized
// instructions compared against a table-level decode model.
module tb_id;

    logic        clk;
    logic        reset;
    logic [31:0] instructionIn;
    logic [8:0]  ALUSrcB;
    logic [3:0]  aluCtl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] immExt;
    logic        illegal;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic [8:0]  ctl;
        logic [3:0]  alu;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t prev;
    bit   have_prev = 0;

    id dut (
        .clk           (clk),
        .reset         (reset),
        .instructionIn (instructionIn),
        .ALUSrcB       (ALUSrcB),
        .aluCtl        (aluCtl),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .immExt        (immExt),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decode straight from the instruction-set table.
    function automatic exp_t model(input logic [31:0] i, input logic rst);
        exp_t e;
        logic [1:0] alu_op;
        e.ctl = 9'h000; e.alu = 4'b0000; e.ill = 1'b0;
        e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0; e.imm = 32'd0;
        if (rst) return e;
        case (i[31:26])
            6'h00:   e.ctl = 9'h122;
            6'h23:   e.ctl = 9'h0F0;
            6'h2B:   e.ctl = 9'h088;
            6'h04:   e.ctl = 9'h005;
            6'h08:   e.ctl = 9'h0A0;
            default: begin e.ctl = 9'h000; e.ill = 1'b1; end
        endcase
        alu_op = e.ctl[1:0];
        if (alu_op == 2'b00)      e.alu = 4'b0010;
        else if (alu_op == 2'b01) e.alu = 4'b0110;
        else begin
            case (i[5:0])
                6'h20:   e.alu = 4'b0010;
                6'h22:   e.alu = 4'b0110;
                6'h24:   e.alu = 4'b0000;
                6'h25:   e.alu = 4'b0001;
                6'h2A:   e.alu = 4'b0111;
                default: begin e.alu = 4'b0000; e.ctl = 9'h000; e.ill = 1'b1; end
            endcase
        end
        e.rs  = i[25:21];
        e.rt  = i[20:16];
        e.rd  = i[15:11];
        e.imm = (i[15] ? 32'hFFFF0000 : 32'h0) | 32'(i[15:0]);
        return e;
    endfunction

    // Drive at the falling edge, confirm outputs still hold the previous result,
    // then check the new result just after the rising edge.
    task automatic apply(input logic [31:0] instr, input logic rst, input string tag);
        exp_t e;
        @(negedge clk);
        instructionIn = instr;
        reset         = rst;
        #1;
        if (have_prev) begin
            check({tag, ".hold_ctl"}, 32'(ALUSrcB), 32'(prev.ctl));
            check({tag, ".hold_ill"}, 32'(illegal), 32'(prev.ill));
            check({tag, ".hold_imm"}, immExt, prev.imm);
        end
        @(posedge clk);
        #1;
        e = model(instr, rst);
        check({tag, ".ALUSrcB"}, 32'(ALUSrcB), 32'(e.ctl));
        check({tag, ".aluCtl"},  32'(aluCtl),  32'(e.alu));
        check({tag, ".rs"},      32'(rs),      32'(e.rs));
        check({tag, ".rt"},      32'(rt),      32'(e.rt));
        check({tag, ".rd"},      32'(rd),      32'(e.rd));
        check({tag, ".immExt"},  immExt,       e.imm);
        check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        prev      = e;
        have_prev = 1;
    endtask

    logic [5:0] op_pool [6];
    logic [5:0] fn_pool [6];

    initial begin
        op_pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        reset         = 1'b1;
        instructionIn = 32'hFFFFFFFF;

        apply(32'hFFFFFFFF, 1'b1, "reset0");
        apply(32'hFFFFFFFF, 1'b1, "reset1");
        check("reset.zero_ctl", 32'(ALUSrcB), 32'h0);
        apply(32'h8C050014, 1'b0, "lw");
        apply(32'h00AA5820, 1'b0, "add");
        apply(32'h00AA5822, 1'b0, "sub");
        apply(32'h00AA5824, 1'b0, "and");
        apply(32'h00AA5825, 1'b0, "or");
        apply(32'h00AA582A, 1'b0, "slt");
        apply(32'hAC0B0000, 1'b0, "sw");
        apply(32'h1085FFFF, 1'b0, "beq_neg");
        apply(32'h2102007F, 1'b0, "addi");
        apply(32'hFC000000, 1'b0, "op3f");
        apply(32'h00000000, 1'b0, "nop");
        apply(32'h00AA5821, 1'b0, "bad_funct");
        apply(32'h8C050014, 1'b0, "lw_again");
        apply(32'h8C050014, 1'b1, "reset_wins");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] instr;
            logic        rst;
            instr = $urandom;
            if ($urandom_range(0, 3) != 0)
                instr[31:26] = op_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) != 0)
                instr[5:0] = fn_pool[$urandom_range(0, 5)];
            rst = ($urandom_range(0, 19) == 0);
            apply(instr, rst, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
